// File: rtl/oled_glyph_serializer.sv
// Serializes an 8x8 glyph fetched from a character ROM onto the OLED SPI pins,
// column bytes left to right, MSB first, with sclk idling high.
module oled_glyph_serializer #(
    parameter int SCLK_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  char_code,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [6:0]  rom_addr,
    input  logic [63:0] rom_data,
    output logic        sclk,
    output logic        sdin,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FETCH    = 3'd1;
    localparam logic [2:0] SHIFT_LO = 3'd2;
    localparam logic [2:0] SHIFT_HI = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    localparam logic [7:0] HALF_LAST = 8'(SCLK_DIV - 1);

    logic [2:0]  state;
    logic [63:0] shreg;
    logic [6:0]  bitcnt;
    logic [6:0]  bitcnt_inc;
    logic [7:0]  hcnt;
    logic        half_end;

    assign half_end   = (hcnt == HALF_LAST);
    assign bitcnt_inc = bitcnt + 7'd1;

    // Gated by rst_n so the block never advertises readiness while held in reset.
    assign char_ready = rst_n && (state == IDLE);
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    // NOTE: every register below is updated with <= so all state sees the
    // pre-edge values of its neighbours, exactly like the flops it infers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rom_addr <= '0;
            shreg    <= '0;
            bitcnt   <= '0;
            hcnt     <= '0;
            sclk     <= 1'b1;
            sdin     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (char_valid) begin
                        rom_addr <= char_code;
                        hcnt     <= '0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    shreg  <= rom_data;
                    bitcnt <= '0;
                    hcnt   <= '0;
                    sclk   <= 1'b0;
                    sdin   <= rom_data[63];
                    state  <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (half_end) begin
                        hcnt  <= '0;
                        sclk  <= 1'b1;
                        state <= SHIFT_HI;
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (half_end) begin
                        hcnt   <= '0;
                        shreg  <= {shreg[62:0], 1'b0};
                        bitcnt <= bitcnt_inc;
                        if (bitcnt_inc == 7'd64) begin
                            sdin  <= 1'b0;
                            state <= DONE;
                        end else begin
                            // Next bit is presented together with the falling sclk.
                            sclk  <= 1'b0;
                            sdin  <= shreg[62];
                            state <= SHIFT_LO;
                        end
                    end else begin
                        hcnt <= hcnt + 8'd1;
                    end
                end
                DONE: begin
                    hcnt  <= '0;
                    state <= IDLE;
                end
                default: begin
                    sclk  <= 1'b1;
                    sdin  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_glyph_serializer.sv
// Self-checking bench: two serializers (SCLK_DIV 4 and 1) fed by a glyph ROM model,
// with a per-instance scoreboard of glyphs pushed at handshake and checked at done.
module tb_oled_glyph_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [6:0]  char_code_s [2];
    logic        char_valid_s[2];
    logic        char_ready_s[2];
    logic [6:0]  rom_addr_s  [2];
    logic [63:0] rom_data_s  [2];
    logic        sclk_s      [2];
    logic        sdin_s      [2];
    logic        busy_s      [2];
    logic        done_s      [2];
    logic        scramble    [2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] glyph(input logic [6:0] a);
        case (a)
            7'h41:   return 64'h407c4a094a7c4000;
            7'h7F:   return 64'hAA55AA55AA55AA55;
            7'h21:   return 64'h0000005f00000000;
            7'h30:   return 64'h003e4549513e0000;
            7'h31:   return 64'h0000427f40000000;
            default: return {8{1'b1, a}};
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int DIV = (g == 0) ? 4 : 1;

        assign rom_data_s[g] = glyph(rom_addr_s[g]) ^ {64{scramble[g]}};

        oled_glyph_serializer #(.SCLK_DIV(DIV)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .char_code  (char_code_s[g]),
            .char_valid (char_valid_s[g]),
            .char_ready (char_ready_s[g]),
            .rom_addr   (rom_addr_s[g]),
            .rom_data   (rom_data_s[g]),
            .sclk       (sclk_s[g]),
            .sdin       (sdin_s[g]),
            .busy       (busy_s[g]),
            .done       (done_s[g])
        );

        logic [63:0] exp_q[$];
        logic [63:0] acc;
        int          nbits;
        int          run;
        int          done_cnt  = 0;
        int          ready_cnt = 0;
        logic        prev_sclk, prev_sdin;
        bit          stable_ok, phase_ok;

        always @(negedge clk) begin
            if (!rst_n) begin
                exp_q.delete();
                acc       = '0;
                nbits     = 0;
                run       = 0;
                prev_sclk = 1'b1;
                prev_sdin = 1'b0;
                stable_ok = 1'b1;
                phase_ok  = 1'b1;
            end else begin
                if (char_valid_s[g] && char_ready_s[g])
                    exp_q.push_back(glyph(char_code_s[g]));
                if (char_ready_s[g])
                    ready_cnt++;
                if (sclk_s[g] != prev_sclk) begin
                    if (sclk_s[g]) begin
                        acc = {acc[62:0], sdin_s[g]};
                        nbits++;
                        if (sdin_s[g] !== prev_sdin) stable_ok = 1'b0;
                        if (run != DIV) phase_ok = 1'b0;
                    end else if (nbits > 0 && run != DIV) begin
                        phase_ok = 1'b0;
                    end
                    run = 1;
                end else begin
                    run++;
                end
                if (done_s[g]) begin
                    done_cnt++;
                    check($sformatf("done_has_pending_char[%0d]", g), 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0)
                        check($sformatf("glyph_bits[%0d]", g), acc, exp_q.pop_front());
                    check($sformatf("bit_count[%0d]", g), 64'(nbits), 64'd64);
                    check($sformatf("sdin_stable[%0d]", g), 64'(stable_ok), 64'd1);
                    check($sformatf("sclk_phase_len[%0d]", g), 64'(phase_ok), 64'd1);
                    acc       = '0;
                    nbits     = 0;
                    stable_ok = 1'b1;
                    phase_ok  = 1'b1;
                end
                prev_sclk = sclk_s[g];
                prev_sdin = sdin_s[g];
            end
        end
    end

    typedef struct {
        int         inst;
        logic [6:0] code;
        int         lat;
    } vec_t;

    vec_t vecs[4];

    task automatic wait_ready(input int i);
        int k = 0;
        @(negedge clk);
        while (!char_ready_s[i] && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("handshake_reached", 64'(char_ready_s[i]), 64'd1);
    endtask

    // Returns the cycle index (handshake = 0) in which done is observed.
    task automatic wait_done(input int i, output int lat);
        lat = 1;
        @(negedge clk);
        while (!done_s[i] && lat < 3000) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic start(input int i, input logic [6:0] code);
        @(posedge clk); #1;
        char_code_s[i]  = code;
        char_valid_s[i] = 1'b1;
        wait_ready(i);
        @(posedge clk); #1;
        char_valid_s[i] = 1'b0;
    endtask

    initial begin
        int lat, r0, d0, k;

        vecs[0] = '{inst: 0, code: 7'h41, lat: 514};
        vecs[1] = '{inst: 0, code: 7'h7F, lat: 514};
        vecs[2] = '{inst: 1, code: 7'h21, lat: 130};
        vecs[3] = '{inst: 1, code: 7'h41, lat: 130};

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            char_code_s[i]  = '0;
            char_valid_s[i] = 1'b0;
            scramble[i]     = 1'b0;
        end

        #12;
        for (int i = 0; i < 2; i++) begin
            check("rst_sclk",     64'(sclk_s[i]),       64'd1);
            check("rst_sdin",     64'(sdin_s[i]),       64'd0);
            check("rst_busy",     64'(busy_s[i]),       64'd0);
            check("rst_done",     64'(done_s[i]),       64'd0);
            check("rst_ready",    64'(char_ready_s[i]), 64'd0);
            check("rst_rom_addr", 64'(rom_addr_s[i]),   64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 64'(char_ready_s[0]), 64'd1);

        // Single characters on both clock dividers.
        for (int v = 0; v < 4; v++) begin
            start(vecs[v].inst, vecs[v].code);
            wait_done(vecs[v].inst, lat);
            check($sformatf("done_latency_%h", vecs[v].code), 64'(lat), 64'(vecs[v].lat));
            check($sformatf("rom_addr_%h", vecs[v].code), 64'(rom_addr_s[vecs[v].inst]), 64'(vecs[v].code));
        end

        // Back-to-back characters with char_valid held high.
        d0 = g_dut[0].done_cnt;
        @(posedge clk); #1;
        char_code_s[0]  = 7'h30;
        char_valid_s[0] = 1'b1;
        wait_ready(0);
        @(posedge clk); #1;
        char_code_s[0] = 7'h31;
        r0 = g_dut[0].ready_cnt;
        wait_ready(0);
        @(posedge clk); #1;
        char_valid_s[0] = 1'b0;
        check("b2b_ready_cycles", 64'(g_dut[0].ready_cnt - r0), 64'd1);
        check("b2b_rom_addr", 64'(rom_addr_s[0]), 64'h31);
        k = 0;
        while (g_dut[0].done_cnt < d0 + 2 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("b2b_done_count", 64'(g_dut[0].done_cnt - d0), 64'd2);

        // Activity on char_valid/char_code/rom_data while shifting must not disturb the glyph.
        d0 = g_dut[0].done_cnt;
        start(0, 7'h41);
        repeat (100) @(posedge clk);
        #1;
        char_code_s[0]  = 7'h55;
        char_valid_s[0] = 1'b1;
        scramble[0]     = 1'b1;
        @(posedge clk); #1;
        char_valid_s[0] = 1'b0;
        char_code_s[0]  = 7'h12;
        repeat (50) @(posedge clk);
        #1;
        char_valid_s[0] = 1'b1;
        @(posedge clk); #1;
        char_valid_s[0] = 1'b0;
        check("busy_mid_glyph", 64'(busy_s[0]), 64'd1);
        check("rom_addr_held", 64'(rom_addr_s[0]), 64'h41);
        wait_done(0, lat);
        scramble[0] = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("single_done_despite_pulses", 64'(g_dut[0].done_cnt - d0), 64'd1);

        // Reset in the middle of bit 20, then a clean character.
        d0 = g_dut[0].done_cnt;
        start(0, 7'h41);
        k = 0;
        while (g_dut[0].nbits < 20 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("reached_bit_20", 64'(g_dut[0].nbits), 64'd20);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_sclk",  64'(sclk_s[0]),       64'd1);
        check("midrst_sdin",  64'(sdin_s[0]),       64'd0);
        check("midrst_busy",  64'(busy_s[0]),       64'd0);
        check("midrst_ready", 64'(char_ready_s[0]), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_midrst", 64'(char_ready_s[0]), 64'd1);
        repeat (10) @(posedge clk);
        check("no_done_after_abort", 64'(g_dut[0].done_cnt - d0), 64'd0);
        start(0, 7'h7F);
        wait_done(0, lat);
        check("post_reset_latency", 64'(lat), 64'd514);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained_0", 64'(g_dut[0].exp_q.size()), 64'd0);
        check("scoreboard_drained_1", 64'(g_dut[1].exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
